// File: rtl/async_fifo_pkg.sv
// Shared helpers for both sides of the dual-clock FIFO: Gray/binary conversion
// and the depth derived from the RAM address width.
package async_fifo_pkg;

  localparam int unsigned DEFAULT_ADDRSIZE = 4;
  localparam int unsigned FIFO_DEPTH       = 2 ** DEFAULT_ADDRSIZE;

  function automatic int unsigned fifo_depth(input int unsigned addrsize);
    return 2 ** addrsize;
  endfunction

  // Operands are zero-extended to 32 bits, so one function serves any pointer width.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of every Gray bit at or above its position.
  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin = '0;
    for (int i = 0; i < 32; i++) begin
      bin[i] = ^(gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-stage reset-to-0 synchronizer for a Gray-coded pointer crossing clock domains.
module sync_2ff #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q1;

  // NOTE: clocked state uses non-blocking assignments so both stages sample
  // the pre-edge values; blocking here would collapse the two flops into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1 <= '0;
      q  <= '0;
    end else begin
      q1 <= d;
      q  <= q1;
    end
  end

endmodule

// File: rtl/wptr_full_level.sv
// Write-side control of the dual-clock FIFO: binary/Gray write pointer, full,
// almost-full, write-side fill level and sticky overflow.
module wptr_full_level
  import async_fifo_pkg::*;
#(
  parameter int unsigned ADDRSIZE     = DEFAULT_ADDRSIZE,
  parameter int unsigned AFULL_THRESH = 14
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic                wovf_clr,
  input  logic [ADDRSIZE:0]   rptr,
  output logic                wen,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                awfull,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                woverflow
);

  localparam int unsigned PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] THRESH = PW'(AFULL_THRESH);

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbinnext;
  logic [PW-1:0] wgraynext;
  logic [PW-1:0] wq2_rptr;
  logic [PW-1:0] wq2_rbin;
  logic [PW-1:0] wlevel_val;
  logic          wfull_val;
  logic          awfull_val;

  sync_2ff #(.WIDTH(PW)) u_rptr_sync (
    .clk   (wclk),
    .rst_n (wrst_n),
    .d     (rptr),
    .q     (wq2_rptr)
  );

  // NOTE: every signal written here gets a value on every pass, so no latch is inferred.
  always_comb begin
    wen        = winc & ~wfull;
    wbinnext   = wbin + PW'(wen);
    wgraynext  = PW'(bin2gray(32'(wbinnext)));
    wq2_rbin   = PW'(gray2bin(32'(wq2_rptr)));
    // Full when the next write pointer has lapped the read pointer by exactly one depth.
    wfull_val  = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});
    wlevel_val = wbinnext - wq2_rbin;
    awfull_val = (wlevel_val >= THRESH);
  end

  assign waddr = wbin[ADDRSIZE-1:0];

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin   <= '0;
      wptr   <= '0;
      wfull  <= 1'b0;
      awfull <= 1'b0;
      wlevel <= '0;
    end else begin
      wbin   <= wbinnext;
      wptr   <= wgraynext;
      wfull  <= wfull_val;
      awfull <= awfull_val;
      wlevel <= wlevel_val;
    end
  end

  // A write attempt while full takes priority over a same-cycle clear.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      woverflow <= 1'b0;
    end else if (winc && wfull) begin
      woverflow <= 1'b1;
    end else if (wovf_clr) begin
      woverflow <= 1'b0;
    end
  end

endmodule
